// File: rtl/cla_serial_add_ctrl.sv
// Digit-serial 28-bit adder: one 4-bit carry-lookahead slice reused over 7 cycles,
// with valid/ready handshakes on the operand and result sides.
module cla_serial_add_ctrl #(
    parameter int WIDTH = 28,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sum_r;
    logic [IDXW-1:0]  idx;
    logic             carry, cout_r, ovf_r;
    logic [SLICE-1:0] nib_a, nib_b, nib_s;
    logic             nib_c3, nib_c4;

    // Returns {c4, c3, sum}; c3 is kept so the final pass can report signed overflow.
    function automatic logic [SLICE+1:0] cla4(input logic [SLICE-1:0] a,
                                              input logic [SLICE-1:0] b,
                                              input logic             cin);
        logic [SLICE-1:0] p, g;
        logic [SLICE:0]   c;
        p    = a | b;
        g    = a & b;
        c[0] = cin;
        for (int k = 0; k < SLICE; k++) c[k+1] = g[k] | (p[k] & c[k]);
        return {c[SLICE], c[SLICE-1], (p & ~g) ^ c[SLICE-1:0]};
    endfunction

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IDXW'(k)) begin
                nib_a = opa[k*SLICE +: SLICE];
                nib_b = opb[k*SLICE +: SLICE];
            end
        end
        {nib_c4, nib_c3, nib_s} = cla4(nib_a, nib_b, carry);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on the accept edge; operands need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            opa <= in_a;
            opb <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx   <= '0;
                        carry <= in_cin;
                    end
                end
                RUN: begin
                    carry <= nib_c4;
                    for (int k = 0; k < NSLICE; k++) begin
                        if (idx == IDXW'(k)) sum_r[k*SLICE +: SLICE] <= nib_s;
                    end
                    if (idx == LAST) begin
                        idx    <= '0;
                        cout_r <= nib_c4;
                        ovf_r  <= nib_c3 ^ nib_c4;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_r;
    assign out_cout = cout_r;
    assign out_ovf  = ovf_r;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Self-checking bench for cla_serial_add_ctrl: directed corner cases, backpressure,
// abort by reset, and a randomized back-to-back sweep against an arithmetic model.
module tb_cla_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_a = '0;
    logic [27:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [27:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cla_serial_add_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {ovf, cout, sum} from plain 29-bit arithmetic and the sign rule.
    function automatic logic [29:0] ref_add(input logic [27:0] a, input logic [27:0] b,
                                            input logic c);
        logic [28:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + 29'(c);
        v = (a[27] == b[27]) && (s[27] != a[27]);
        return {v, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, scrambles the operand bus after acceptance, and waits for out_valid.
    task automatic send_op(input logic [27:0] a, input logic [27:0] b, input logic c,
                           output int lat, output bit ok);
        int n;
        bit acc;
        ok = 1'b1;
        lat = 0;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 30);
        in_valid = 1'b0;
        in_a = 28'($urandom); in_b = 28'($urandom); in_cin = 1'($urandom);
        if (!acc) begin
            ok = 1'b0;
            return;
        end
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!out_valid) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_sum !== 28'h0)  begin n_fail++; $display("FAIL reset_sum: got %h want 0", out_sum); end
        n_checks++; if (out_cout !== 1'b0)  begin n_fail++; $display("FAIL reset_cout: got %b want 0", out_cout); end
        n_checks++; if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [27:0] va [5];
        logic [27:0] vb [5];
        logic        vc [5];
        logic [27:0] es [5];
        logic        ec [5];
        logic        eo [5];
        int lat;
        bit ok;
        va[0] = 28'h0FFFFFF; vb[0] = 28'h0000001; vc[0] = 0; es[0] = 28'h1000000; ec[0] = 0; eo[0] = 0;
        va[1] = 28'hFFFFFFF; vb[1] = 28'h0000001; vc[1] = 0; es[1] = 28'h0000000; ec[1] = 1; eo[1] = 0;
        va[2] = 28'h0000000; vb[2] = 28'h0000000; vc[2] = 1; es[2] = 28'h0000001; ec[2] = 0; eo[2] = 0;
        va[3] = 28'h7FFFFFF; vb[3] = 28'h0000001; vc[3] = 0; es[3] = 28'h8000000; ec[3] = 0; eo[3] = 1;
        va[4] = 28'h8000000; vb[4] = 28'h8000000; vc[4] = 0; es[4] = 28'h0000000; ec[4] = 1; eo[4] = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_op(va[i], vb[i], vc[i], lat, ok);
            n_checks++; if (!ok || lat != 7) begin n_fail++; $display("FAIL dir%0d_latency: got %0d (ok=%0b) want 7", i, lat, ok); end
            n_checks++; if (out_sum !== es[i])  begin n_fail++; $display("FAIL dir%0d_sum: got %h want %h", i, out_sum, es[i]); end
            n_checks++; if (out_cout !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout: got %b want %b", i, out_cout, ec[i]); end
            n_checks++; if (out_ovf !== eo[i])  begin n_fail++; $display("FAIL dir%0d_ovf: got %b want %b", i, out_ovf, eo[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        out_ready = 1'b0;
        send_op(28'h1234567, 28'h7654321, 1'b0, lat, ok);
        n_checks++; if (!ok || lat != 7) begin n_fail++; $display("FAIL bp_latency: got %0d (ok=%0b) want 7", lat, ok); end
        in_a = 28'h0000111; in_b = 28'h0000222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
            n_checks++; if (out_sum !== 28'h8888888) begin n_fail++; $display("FAIL bp_hold_sum%0d: got %h want 8888888", i, out_sum); end
            n_checks++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b1)       begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0)      begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL bp_release_busy: got %b want 0", busy); end
        n_checks++; if (out_sum !== 28'h8888888) begin n_fail++; $display("FAIL bp_keep_sum: got %h want 8888888", out_sum); end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat;
        bit ok;
        in_a = 28'hABCDEF1; in_b = 28'h1111111; in_cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_started: got busy %b want 1", busy); end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (out_sum !== 28'h0)  begin n_fail++; $display("FAIL abort_sum_cleared: got %h want 0", out_sum); end
        out_ready = 1'b1;
        send_op(28'h0000003, 28'h0000004, 1'b0, lat, ok);
        n_checks++; if (!ok || lat != 7)        begin n_fail++; $display("FAIL post_abort_latency: got %0d (ok=%0b) want 7", lat, ok); end
        n_checks++; if (out_sum !== 28'h0000007) begin n_fail++; $display("FAIL post_abort_sum: got %h want 0000007", out_sum); end
        n_checks++; if (out_cout !== 1'b0)       begin n_fail++; $display("FAIL post_abort_cout: got %b want 0", out_cout); end
        n_checks++; if (out_ovf !== 1'b0)        begin n_fail++; $display("FAIL post_abort_ovf: got %b want 0", out_ovf); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [27:0] a, b;
        logic        c;
        logic [29:0] exp;
        int prev, n, lat;
        bit acc;
        prev = 0;
        out_ready = 1'b1;
        a = 28'($urandom); b = 28'($urandom); c = 1'($urandom);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            do begin
                acc = in_ready;
                tick();
                n++;
            end while (!acc && n < 30);
            n_checks++;
            if (!acc) begin n_fail++; $display("FAIL b2b%0d_accept: no acceptance within 30 cycles", i); break; end
            if (i > 0) begin
                n_checks++;
                if (cyc - prev != 9) begin n_fail++; $display("FAIL b2b%0d_interval: got %0d want 9", i, cyc - prev); end
            end
            prev = cyc;
            exp = ref_add(a, b, c);
            a = 28'($urandom); b = 28'($urandom); c = 1'($urandom);
            in_a = a; in_b = b; in_cin = c;
            if (i == 999) in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 30) begin
                tick();
                lat++;
            end
            n_checks++; if (lat != 7) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d want 7", i, lat); end
            n_checks++;
            if ({out_ovf, out_cout, out_sum} !== exp) begin
                n_fail++;
                $display("FAIL b2b%0d_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                         i, out_ovf, out_cout, out_sum, exp[29], exp[28], exp[27:0]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
